mcp47_dac_multi_updater: RTL
============================

// Module: mcp47_dac_multi_updater
// PURPOSE
//  Multi-channel update sequencer for an MCP47FEBxx-family I2C DAC. Snapshots NUM_CH channel codes on
//  request, writes only masked channels whose code changed since last successful write, retries
//  NACKed transfers, and reports per-channel errors. Drives the cmd/data stream ports of an external
//  i2c_master (instantiated by the parent, stop_on_idle=1); no pad logic inside.
// PARAMETERS
//  NUM_CH     2        channels, 1..8; channel n -> DAC register address n
//  VAL_W      12       code width, 8..16; zero-extended to 16 bits on the wire
//  DEV_ADDR   7'h60    7-bit I2C device address
//  MAX_RETRY  2        re-attempts per channel after missed_ack (0 = none)
// PORTS
//  clk            in   1              clock
//  rst            in   1              reset, asynchronous, active-high
//  ch_value       in   NUM_CH*VAL_W   channel codes, ch n at [n*VAL_W +: VAL_W]
//  ch_mask        in   NUM_CH         1 = channel eligible this update
//  force          in   1              1 = write eligible channels even if unchanged
//  update_req     in   1              1-cycle request pulse
//  busy           out  1              high from accept to done
//  done           out  1              1-cycle pulse at end of update
//  err            out  1              sticky, any channel exhausted retries; cleared by next accept
//  err_ch         out  NUM_CH         sticky per-channel failure flags; cleared by next accept
//  cmd_address/cmd_start/cmd_write_multiple/cmd_stop/cmd_valid  out  7/1/1/1/1  to i2c_master
//  cmd_ready      in   1
//  data_in        out  8;  data_in_valid, data_in_last out 1;  data_in_ready in 1
//  i2c_busy, missed_ack  in  1        from i2c_master
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shadow_valid[] = 0 (first update writes every masked channel).
//  Accept: IDLE && (update_req || pend) -> latch ch_value, ch_mask, force; clear err/err_ch, pend; busy=1.
//  update_req while busy -> pend=1 (single-depth, further pulses merge); serviced right after done.
//  SCAN: idx 0..NUM_CH-1, one channel per cycle; write if mask[idx] && (force || !shadow_valid[idx]
//   || shadow[idx] != snap[idx]); else skip. idx past NUM_CH-1 -> DONE.
//  CMD: cmd_valid=1, start=1, write_multiple=1, stop=1, address=DEV_ADDR; hold until cmd_valid&&cmd_ready.
//  B0/B1/B2: data_in = {idx[4:0],2'b00,1'b0}, then code16[15:8], then code16[7:0] with data_in_last=1;
//   each byte held stable until data_in_valid&&data_in_ready, then next; valid deasserts after B2 beat.
//  WAIT: until !i2c_busy (min 2 cycles after last beat). nack flag = OR of missed_ack over CMD..WAIT.
//  Result: no nack -> shadow[idx]=snap, shadow_valid=1, next channel. nack && tries<MAX_RETRY ->
//   tries++, back to CMD. nack at limit -> err=1, err_ch[idx]=1, shadow unchanged, next channel.
//  DONE: done=1 one cycle, busy=0 same cycle, -> IDLE. All-skipped update still pulses done.
//  Latency: accept->first cmd_valid = 2 cycles when channel 0 needs a write.
//  ch_value changes during busy ignored (snapshot). rst mid-transfer: valids drop immediately, shadows
//   invalidated; i2c_master is reset by the same rst.
// STRUCTURE
//  Package mcp47_pkg: MCP47_DEV_ADDR, register-address/command-bit constants (CMD_WRITE=2'b00,
//   CMD_READ=2'b11), state enum {IDLE,SCAN,CMD,B0,B1,B2,WAIT,NEXT,DONE}.
//  Single module; shadow registers as NUM_CH x 16 flop array; no sub-module needed.
// TESTING (i2c_master replaced by BFM with programmable ready delays and NACK injection)
//  Reset, update_req, mask=2'b11, codes 12'h123/12'hABC -> two transfers: 00,01,23 then 08,0A,BC; done.
//  Repeat same codes, force=0 -> no cmd_valid, done within NUM_CH+3 cycles; force=1 -> both rewritten.
//  Change ch1 only to 12'h7FF, mask=2'b11 -> single transfer 08,07,FF.
//  NACK ch0 always, MAX_RETRY=2 -> 3 attempts, err=1, err_ch=2'b01, ch1 still written.
//  update_req pulsed 3x during busy -> exactly one extra update after done, with new snapshot.
//  rst asserted during B1 -> all outputs 0 same edge; next update rewrites every masked channel.

Source files
------------

// File: rtl/mcp47_pkg.sv
// Shared constants, command-byte helper and sequencer state encoding for the
// MCP47FEBxx multi-channel DAC update sequencer.
package mcp47_pkg;

    localparam logic [6:0] MCP47_DEV_ADDR = 7'h60;
    localparam logic [1:0] CMD_WRITE      = 2'b00;
    localparam logic [1:0] CMD_READ       = 2'b11;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        SCAN = 4'd1,
        CMD  = 4'd2,
        B0   = 4'd3,
        B1   = 4'd4,
        B2   = 4'd5,
        WAIT = 4'd6,
        NEXT = 4'd7,
        DONE = 4'd8
    } state_t;

    // First wire byte: register address in [7:3], command bits in [2:1], bit 0 reserved.
    function automatic logic [7:0] cmd_byte(input logic [4:0] reg_addr, input logic [1:0] cmd);
        return {reg_addr, cmd, 1'b0};
    endfunction

endpackage

// File: rtl/mcp47_dac_multi_updater.sv
// Snapshots NUM_CH DAC codes on request and writes the changed (or forced) masked
// channels through an external i2c_master, retrying NACKed transfers.
module mcp47_dac_multi_updater
    import mcp47_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned VAL_W     = 12,
    parameter logic [6:0]  DEV_ADDR  = MCP47_DEV_ADDR,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*VAL_W-1:0] ch_value,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic                    force_update,
    input  logic                    update_req,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [NUM_CH-1:0]       err_ch,
    output logic [6:0]              cmd_address,
    output logic                    cmd_start,
    output logic                    cmd_write_multiple,
    output logic                    cmd_stop,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [7:0]              data_in,
    output logic                    data_in_valid,
    output logic                    data_in_last,
    input  logic                    data_in_ready,
    input  logic                    i2c_busy,
    input  logic                    missed_ack
);

    function automatic logic [15:0] ext16(input logic [VAL_W-1:0] v);
        logic [15:0] r;
        r = 16'h0000;
        r[VAL_W-1:0] = v;
        return r;
    endfunction

    state_t             state_r;
    logic [4:0]         idx_r;
    logic [3:0]         tries_r;
    logic [1:0]         wait_cnt_r;
    logic               nack_r;
    logic               pend_r;
    logic [15:0]        snap_val_r [NUM_CH];
    logic [NUM_CH-1:0]  snap_mask_r;
    logic               snap_force_r;
    logic [15:0]        shadow_r [NUM_CH];
    logic [NUM_CH-1:0]  shadow_valid_r;

    logic [15:0]        cur_code_s;
    logic [15:0]        cur_shadow_s;
    logic               cur_mask_s;
    logic               cur_valid_s;
    logic               need_write_s;
    logic               nack_any_s;
    logic               last_ch_s;

    // Select the current channel's snapshot/shadow and decide whether it needs a write.
    always_comb begin
        cur_code_s   = 16'h0000;
        cur_shadow_s = 16'h0000;
        cur_mask_s   = 1'b0;
        cur_valid_s  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cur_code_s   = cur_code_s   | ((idx_r == 5'(i)) ? snap_val_r[i] : 16'h0000);
            cur_shadow_s = cur_shadow_s | ((idx_r == 5'(i)) ? shadow_r[i]   : 16'h0000);
            cur_mask_s   = cur_mask_s   | ((idx_r == 5'(i)) & snap_mask_r[i]);
            cur_valid_s  = cur_valid_s  | ((idx_r == 5'(i)) & shadow_valid_r[i]);
        end
        need_write_s = cur_mask_s & (snap_force_r | ~cur_valid_s | (cur_shadow_s != cur_code_s));
        nack_any_s   = nack_r | missed_ack;
        last_ch_s    = (idx_r == 5'(NUM_CH - 1));
    end

    // Sequencer FSM with registered handshake, status and shadow state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r            <= IDLE;
            idx_r              <= 5'd0;
            tries_r            <= 4'd0;
            wait_cnt_r         <= 2'd0;
            nack_r             <= 1'b0;
            pend_r             <= 1'b0;
            snap_mask_r        <= '0;
            snap_force_r       <= 1'b0;
            shadow_valid_r     <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            err_ch             <= '0;
            cmd_address        <= 7'h00;
            cmd_start          <= 1'b0;
            cmd_write_multiple <= 1'b0;
            cmd_stop           <= 1'b0;
            cmd_valid          <= 1'b0;
            data_in            <= 8'h00;
            data_in_valid      <= 1'b0;
            data_in_last       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_val_r[i] <= 16'h0000;
                shadow_r[i]   <= 16'h0000;
            end
        end else begin
            if (update_req && (state_r != IDLE)) begin
                pend_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (update_req || pend_r) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            snap_val_r[i] <= ext16(ch_value[i*VAL_W +: VAL_W]);
                        end
                        snap_mask_r  <= ch_mask;
                        snap_force_r <= force_update;
                        err          <= 1'b0;
                        err_ch       <= '0;
                        pend_r       <= 1'b0;
                        busy         <= 1'b1;
                        idx_r        <= 5'd0;
                        state_r      <= SCAN;
                    end
                end
                SCAN: begin
                    if (need_write_s) begin
                        tries_r            <= 4'd0;
                        nack_r             <= 1'b0;
                        cmd_address        <= DEV_ADDR;
                        cmd_start          <= 1'b1;
                        cmd_write_multiple <= 1'b1;
                        cmd_stop           <= 1'b1;
                        cmd_valid          <= 1'b1;
                        state_r            <= CMD;
                    end else if (last_ch_s) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        idx_r <= idx_r + 5'd1;
                    end
                end
                CMD: begin
                    nack_r <= nack_any_s;
                    if (cmd_ready) begin
                        cmd_address        <= 7'h00;
                        cmd_start          <= 1'b0;
                        cmd_write_multiple <= 1'b0;
                        cmd_stop           <= 1'b0;
                        cmd_valid          <= 1'b0;
                        data_in            <= cmd_byte(idx_r, CMD_WRITE);
                        data_in_valid      <= 1'b1;
                        state_r            <= B0;
                    end
                end
                B0: begin
                    nack_r <= nack_any_s;
                    if (data_in_ready) begin
                        data_in <= cur_code_s[15:8];
                        state_r <= B1;
                    end
                end
                B1: begin
                    nack_r <= nack_any_s;
                    if (data_in_ready) begin
                        data_in      <= cur_code_s[7:0];
                        data_in_last <= 1'b1;
                        state_r      <= B2;
                    end
                end
                B2: begin
                    nack_r <= nack_any_s;
                    if (data_in_ready) begin
                        data_in       <= 8'h00;
                        data_in_valid <= 1'b0;
                        data_in_last  <= 1'b0;
                        wait_cnt_r    <= 2'd0;
                        state_r       <= WAIT;
                    end
                end
                WAIT: begin
                    nack_r <= nack_any_s;
                    // Hold off two cycles so the master has raised i2c_busy for the stop phase.
                    if (wait_cnt_r != 2'd2) begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end else if (!i2c_busy) begin
                        if (!nack_any_s) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (idx_r == 5'(i)) begin
                                    shadow_r[i]       <= cur_code_s;
                                    shadow_valid_r[i] <= 1'b1;
                                end
                            end
                            state_r <= NEXT;
                        end else if (tries_r < 4'(MAX_RETRY)) begin
                            tries_r            <= tries_r + 4'd1;
                            nack_r             <= 1'b0;
                            cmd_address        <= DEV_ADDR;
                            cmd_start          <= 1'b1;
                            cmd_write_multiple <= 1'b1;
                            cmd_stop           <= 1'b1;
                            cmd_valid          <= 1'b1;
                            state_r            <= CMD;
                        end else begin
                            err <= 1'b1;
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (idx_r == 5'(i)) begin
                                    err_ch[i] <= 1'b1;
                                end
                            end
                            state_r <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (last_ch_s) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + 5'd1;
                        state_r <= SCAN;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
